// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The optional statistics counters are built only when DMEM_ARB_STATS_EN is defined.
package dmem_arbiter_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_e;

  localparam int ADDR_W_DEF    = 10;
  localparam int DATA_W_DEF    = 32;
  localparam int BURST_MAX_DEF = 4;
  localparam int STATS_W       = 16;

  // Saturating increment used by the statistics counters.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side access bus of the data-memory arbiter (one instance per requester).
// master = requester (CPU MEM stage or host port), slave = arbiter.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/dmem_arbiter_arb_burst_ctrl.sv
// Owner-based round-robin grant logic with a bounded burst length.
// The owner keeps winning contention until it has taken BURST_MAX grants in a row.
module arb_burst_ctrl
  import dmem_arbiter_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic clk,
  input  logic arst_n,
  input  logic c_req,
  input  logic x_req,
  output logic c_gnt,
  output logic x_gnt
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  owner_e           owner_q, owner_d, gnt_side;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Owner / burst-count state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      owner_q <= OWN_CPU;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant decision and next owner / burst count.
  always_comb begin
    c_gnt    = 1'b0;
    x_gnt    = 1'b0;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    gnt_side = OWN_CPU;

    if (c_req && x_req) begin
      if (cnt_q < CNT_MAX) begin
        c_gnt = (owner_q == OWN_CPU);
        x_gnt = (owner_q == OWN_EXT);
      end else begin
        c_gnt = (owner_q == OWN_EXT);
        x_gnt = (owner_q == OWN_CPU);
      end
    end else begin
      c_gnt = c_req;
      x_gnt = x_req;
    end

    if (c_gnt || x_gnt) begin
      gnt_side = x_gnt ? OWN_EXT : OWN_CPU;
      if (gnt_side == owner_q) begin
        cnt_d = (cnt_q < CNT_MAX) ? cnt_q + 1'b1 : CNT_MAX;
      end else begin
        owner_d = gnt_side;
        cnt_d   = CNT_W'(1);
      end
    end else begin
      // An idle cycle ends the burst but leaves ownership unchanged.
      cnt_d = '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data SRAM arbiter between the CPU MEM stage (c) and the host port (x).
// Grants one access per cycle, returns read data one cycle after the grant and
// stalls the CPU whenever its request is not granted.
// Optional: define DMEM_ARB_STATS_EN to add conflict_cnt / cpu_stall_cnt outputs.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic                clk,
  input  logic                arst_n,
  dmem_arbiter_if.slave       c,
  dmem_arbiter_if.slave       x,
  output logic                cpu_stall,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic                mem_ren,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]  conflict_cnt,
  output logic [STATS_W-1:0]  cpu_stall_cnt
`endif
);

  logic c_gnt, x_gnt;
  logic c_vld_p1, x_vld_p1;

  arb_burst_ctrl #(.BURST_MAX(BURST_MAX)) u_ctrl (
    .clk    (clk),
    .arst_n (arst_n),
    .c_req  (c.req),
    .x_req  (x.req),
    .c_gnt  (c_gnt),
    .x_gnt  (x_gnt)
  );

  assign c.gnt     = c_gnt;
  assign x.gnt     = x_gnt;
  assign cpu_stall = c.req & ~c_gnt;

  // Route the granted port onto the SRAM; bus is zero when nothing is granted.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    if (c_gnt) begin
      mem_addr  = c.addr;
      mem_wdata = c.wdata;
      mem_wen   = c.we;
      mem_ren   = ~c.we;
    end else if (x_gnt) begin
      mem_addr  = x.addr;
      mem_wdata = x.wdata;
      mem_wen   = x.we;
      mem_ren   = ~x.we;
    end
  end

  // ---- stage p1: read-return tag, aligned with the SRAM's 1-cycle read latency ----
  // Remember which side issued a read so its data is steered back next cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      c_vld_p1 <= 1'b0;
      x_vld_p1 <= 1'b0;
    end else begin
      c_vld_p1 <= c_gnt & ~c.we;
      x_vld_p1 <= x_gnt & ~x.we;
    end
  end

  assign c.rvalid = c_vld_p1;
  assign x.rvalid = x_vld_p1;
  assign c.rdata  = c_vld_p1 ? mem_rdata : '0;
  assign x.rdata  = x_vld_p1 ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
  // Saturating counts of contention cycles and CPU stall cycles.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      conflict_cnt  <= '0;
      cpu_stall_cnt <= '0;
    end else begin
      if (c.req && x.req) conflict_cnt  <= sat_inc(conflict_cnt);
      if (cpu_stall)      cpu_stall_cnt <= sat_inc(cpu_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: two instances (BURST_MAX 4 and 1) share the
// same stimulus; sel picks which one is observed. Expected read data is pushed
// when a read is granted and popped on the following cycle.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_n;
  logic          sel;
  logic          mem_init;
  logic          c_req, c_we, x_req, x_we;
  logic [AW-1:0] c_addr, x_addr;
  logic [DW-1:0] c_wdata, x_wdata;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) c0 ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) x0 ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) c1 ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) x1 ();

  assign c0.req = c_req;  assign c0.we = c_we;  assign c0.addr = c_addr;  assign c0.wdata = c_wdata;
  assign x0.req = x_req;  assign x0.we = x_we;  assign x0.addr = x_addr;  assign x0.wdata = x_wdata;
  assign c1.req = c_req;  assign c1.we = c_we;  assign c1.addr = c_addr;  assign c1.wdata = c_wdata;
  assign x1.req = x_req;  assign x1.we = x_we;  assign x1.addr = x_addr;  assign x1.wdata = x_wdata;

  logic          stall0, stall1, m0_wen, m0_ren, m1_wen, m1_ren;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   conf0, conf1, scnt0, scnt1;
`endif

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(4)) u_dut0 (
    .clk(clk), .arst_n(arst_n), .c(c0), .x(x0), .cpu_stall(stall0),
    .mem_addr(m0_addr), .mem_wen(m0_wen), .mem_ren(m0_ren),
    .mem_wdata(m0_wdata), .mem_rdata(m0_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt(conf0), .cpu_stall_cnt(scnt0)
`endif
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(1)) u_dut1 (
    .clk(clk), .arst_n(arst_n), .c(c1), .x(x1), .cpu_stall(stall1),
    .mem_addr(m1_addr), .mem_wen(m1_wen), .mem_ren(m1_ren),
    .mem_wdata(m1_wdata), .mem_rdata(m1_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt(conf1), .cpu_stall_cnt(scnt1)
`endif
  );

  function automatic logic [DW-1:0] pattern(input int a);
    return 32'hA5C3_0000 ^ (a * 32'h0001_0203);
  endfunction

  // SRAM models with 1-cycle read latency.
  logic [DW-1:0] mem0 [0:1023];
  logic [DW-1:0] mem1 [0:1023];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem0[i] <= pattern(i);
    end else begin
      if (m0_wen) mem0[m0_addr] <= m0_wdata;
      if (m0_ren) m0_rdata <= mem0[m0_addr];
    end
  end
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem1[i] <= pattern(i);
    end else begin
      if (m1_wen) mem1[m1_addr] <= m1_wdata;
      if (m1_ren) m1_rdata <= mem1[m1_addr];
    end
  end

  // Observed instance.
  logic          o_c_gnt, o_x_gnt, o_c_rv, o_x_rv, o_stall, o_wen, o_ren;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_c_rd, o_x_rd, o_wdata;
  assign o_c_gnt = sel ? c1.gnt    : c0.gnt;
  assign o_x_gnt = sel ? x1.gnt    : x0.gnt;
  assign o_c_rv  = sel ? c1.rvalid : c0.rvalid;
  assign o_x_rv  = sel ? x1.rvalid : x0.rvalid;
  assign o_c_rd  = sel ? c1.rdata  : c0.rdata;
  assign o_x_rd  = sel ? x1.rdata  : x0.rdata;
  assign o_stall = sel ? stall1    : stall0;
  assign o_wen   = sel ? m1_wen    : m0_wen;
  assign o_ren   = sel ? m1_ren    : m0_ren;
  assign o_addr  = sel ? m1_addr   : m0_addr;
  assign o_wdata = sel ? m1_wdata  : m0_wdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] o_conf, o_scnt;
  assign o_conf = sel ? conf1 : conf0;
  assign o_scnt = sel ? scnt1 : scnt0;
`endif

  typedef struct {
    logic          port;   // 0 = CPU, 1 = external
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t       exp_q[$];
  logic [DW-1:0] ref_mem [0:1023];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc      = 0;
  int            conf_exp = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s cyc=%0d: got %h, expected %h", tag, cyc, got, exp);
    else
      n_pass++;
  endtask

  // One clock cycle with the currently driven inputs and the expected grants.
  task automatic cycle(input logic eg_c, input logic eg_x, input string tag,
                       input logic rst_after = 1'b0);
    rd_exp_t       e;
    logic          ewen, eren;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewdata;
    @(negedge clk);
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "/c_rvalid"}, o_c_rv, !e.port);
      check({tag, "/x_rvalid"}, o_x_rv, e.port);
      check({tag, "/c_rdata"}, o_c_rd, e.port ? '0 : e.data);
      check({tag, "/x_rdata"}, o_x_rd, e.port ? e.data : '0);
    end else begin
      check({tag, "/c_rvalid"}, o_c_rv, 1'b0);
      check({tag, "/x_rvalid"}, o_x_rv, 1'b0);
      check({tag, "/c_rdata"}, o_c_rd, '0);
      check({tag, "/x_rdata"}, o_x_rd, '0);
    end
    ewen   = (eg_c & c_we) | (eg_x & x_we);
    eren   = (eg_c & ~c_we) | (eg_x & ~x_we);
    eaddr  = eg_c ? c_addr  : (eg_x ? x_addr  : '0);
    ewdata = eg_c ? c_wdata : (eg_x ? x_wdata : '0);
    check({tag, "/c_gnt"}, o_c_gnt, eg_c);
    check({tag, "/x_gnt"}, o_x_gnt, eg_x);
    check({tag, "/cpu_stall"}, o_stall, c_req & ~eg_c);
    check({tag, "/mem_wen"}, o_wen, ewen);
    check({tag, "/mem_ren"}, o_ren, eren);
    check({tag, "/mem_addr"}, o_addr, eaddr);
    check({tag, "/mem_wdata"}, o_wdata, ewdata);
    if (eren) exp_q.push_back('{port: eg_x, data: ref_mem[eaddr]});
    if (ewen) ref_mem[eaddr] = ewdata;
    if (arst_n && c_req && x_req) conf_exp++;
    if (rst_after) begin
      arst_n   = 1'b0;
      c_req    = 1'b0;
      x_req    = 1'b0;
      conf_exp = 0;
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    arst_n   = 1'b0;
    c_req    = 1'b0;
    x_req    = 1'b0;
    conf_exp = 0;
    exp_q.delete();
    cycle(1'b0, 1'b0, tag);
`ifdef DMEM_ARB_STATS_EN
    check({tag, "/conflict_cnt"}, o_conf, 0);
    check({tag, "/cpu_stall_cnt"}, o_scnt, 0);
`endif
    arst_n = 1'b1;
  endtask

  initial begin
    arst_n   = 1'b0;
    sel      = 1'b0;
    mem_init = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    x_req = 1'b0; x_we = 1'b0; x_addr = '0; x_wdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pattern(i);
    @(posedge clk);
    #1;
    mem_init = 1'b0;
    do_reset("rst0");

    cycle(1'b0, 1'b0, "idle");
    cycle(1'b0, 1'b0, "idle");

    // CPU-only write then read back.
    c_req = 1'b1; c_we = 1'b1; c_addr = 10'h010; c_wdata = 32'hDEADBEEF;
    cycle(1'b1, 1'b0, "c_wr");
    c_we = 1'b0;
    cycle(1'b1, 1'b0, "c_rd");
    c_req = 1'b0;
    cycle(1'b0, 1'b0, "c_rd_ret");

    // Continuous contention, BURST_MAX = 4: C,C,C,C,X,X,X,X,C,C,C,C.
    c_req = 1'b1; x_req = 1'b1; c_we = 1'b0; x_we = 1'b0;
    c_addr = 10'h020; x_addr = 10'h030;
    for (int i = 0; i < 12; i++) begin
      logic g;
      g = ((i / 4) % 2) == 0;
      cycle(g, !g, "b4");
    end
    c_req = 1'b0; x_req = 1'b0;
    cycle(1'b0, 1'b0, "b4_flush");

    // Idle gap resets the burst count: CPU wins 4 more, then X.
    c_req = 1'b1; c_addr = 10'h040;
    cycle(1'b1, 1'b0, "gap_c");
    cycle(1'b1, 1'b0, "gap_c");
    c_req = 1'b0;
    cycle(1'b0, 1'b0, "gap_idle");
    c_req = 1'b1; x_req = 1'b1; x_addr = 10'h050;
    for (int i = 0; i < 5; i++) cycle(i < 4, i == 4, "gap_both");
    c_req = 1'b0; x_req = 1'b0;
    cycle(1'b0, 1'b0, "gap_flush");

    // BURST_MAX = 1: strict alternation, each read returns on its own port.
    sel = 1'b1;
    do_reset("rst1");
    c_req = 1'b1; x_req = 1'b1; c_addr = 10'h100; x_addr = 10'h200;
    for (int i = 0; i < 8; i++) begin
      logic g;
      g = (i % 2) == 0;
      cycle(g, !g, "b1");
      if (g) c_addr = c_addr + 1'b1;
      else   x_addr = x_addr + 1'b1;
    end
    c_req = 1'b0; x_req = 1'b0;
    cycle(1'b0, 1'b0, "b1_flush");
`ifdef DMEM_ARB_STATS_EN
    check("conflict_cnt", o_conf, conf_exp);
`endif

    // Reset right after an external read grant: no data may come back.
    sel = 1'b0;
    x_req = 1'b1; x_we = 1'b0; x_addr = 10'h055;
    cycle(1'b0, 1'b1, "x_rd_rst", 1'b1);
`ifdef DMEM_ARB_STATS_EN
    check("rst_conflict_cnt", o_conf, 0);
    check("rst_cpu_stall_cnt", o_scnt, 0);
`endif
    cycle(1'b0, 1'b0, "in_rst");
    cycle(1'b0, 1'b0, "in_rst");
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
